// File: rtl/fighter_anim_if.sv
// Bundle between game logic / video timing and one fighter's animation controller.
// The master side drives pixel position, fighter position and requests; the slave returns animation and sprite outputs.
interface fighter_anim_if;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  PosX;
    logic [9:0]  PosY;
    logic        facing_left;
    logic        move_req;
    logic        punch_req;
    logic        hit_req;
    logic [1:0]  anim_state;
    logic [1:0]  frame_idx;
    logic        busy;
    logic        flip;
    logic [12:0] rom_address;
    logic        sprite_on;

    modport master (
        output frame_start, DrawX, DrawY, PosX, PosY, facing_left,
               move_req, punch_req, hit_req,
        input  anim_state, frame_idx, busy, flip, rom_address, sprite_on
    );

    modport slave (
        input  frame_start, DrawX, DrawY, PosX, PosY, facing_left,
               move_req, punch_req, hit_req,
        output anim_state, frame_idx, busy, flip, rom_address, sprite_on
    );
endinterface

// File: rtl/fighter_anim_controller.sv
// Per-fighter animation sequencer (idle/walk/punch/hit-stun) stepped on frame_start,
// plus a registered, scaled and optionally mirrored sprite ROM address generator.
module fighter_anim_controller #(
    parameter int TICKS_PER_FRAME = 8,
    parameter int SPRITE_W        = 60,
    parameter int SPRITE_H        = 90,
    parameter int BOX_W           = 80,
    parameter int BOX_H           = 160,
    parameter int IDLE_FRAMES     = 4,
    parameter int PUNCH_FRAMES    = 3,
    parameter int HIT_FRAMES      = 2
) (
    input  logic          vga_clk,
    input  logic          Reset,
    fighter_anim_if.slave bus
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_FRAME - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [1:0]    IDLE_LAST  = 2'(IDLE_FRAMES - 1);
    localparam logic [1:0]    PUNCH_LAST = 2'(PUNCH_FRAMES - 1);
    localparam logic [1:0]    HIT_LAST   = 2'(HIT_FRAMES - 1);
    localparam logic [16:0]   SPR_W17    = 17'(SPRITE_W);
    localparam logic [16:0]   SPR_H17    = 17'(SPRITE_H);
    localparam logic [16:0]   BOX_W17    = 17'(BOX_W);
    localparam logic [16:0]   BOX_H17    = 17'(BOX_H);
    localparam logic [9:0]    BOX_W10    = 10'(BOX_W);
    localparam logic [9:0]    BOX_H10    = 10'(BOX_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_PUNCH = 2'd2,
        ST_HIT   = 2'd3
    } anim_state_t;

    anim_state_t   state_r, state_n_s, rest_state_s;
    logic [TW-1:0] tick_r, tick_n_s, tick_adv_s;
    logic [1:0]    idx_r, idx_n_s;
    logic [1:0]    stun_r, stun_n_s;
    logic          busy_r, busy_n_s;
    logic          tick_wrap_s;

    logic [9:0]    pos_x_r, pos_y_r;
    logic          flip_r;

    logic [9:0]    rel_x_s, rel_y_s;
    logic          inside_s;
    logic [16:0]   col_s, row_s, col_m_s;
    logic [12:0]   addr_s;
    logic [12:0]   rom_address_r;
    logic          sprite_on_r;

    // Animation state register, stepped only through the next-state logic.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            tick_r  <= {TW{1'b0}};
            idx_r   <= 2'd0;
            stun_r  <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            tick_r  <= tick_n_s;
            idx_r   <= idx_n_s;
            stun_r  <= stun_n_s;
            busy_r  <= busy_n_s;
        end
    end

    // Next-state logic: hit beats punch beats move; every state entry clears tick/frame/stun.
    always_comb begin
        state_n_s    = state_r;
        tick_n_s     = tick_r;
        idx_n_s      = idx_r;
        stun_n_s     = stun_r;
        tick_wrap_s  = (tick_r == TICK_LAST);
        tick_adv_s   = tick_wrap_s ? {TW{1'b0}} : (tick_r + TICK_ONE);
        rest_state_s = bus.move_req ? ST_WALK : ST_IDLE;

        if (bus.frame_start) begin
            tick_n_s = tick_adv_s;
            if (bus.hit_req) begin
                state_n_s = ST_HIT;
                tick_n_s  = {TW{1'b0}};
                idx_n_s   = 2'd0;
                stun_n_s  = 2'd0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_WALK: begin
                        if (bus.punch_req) begin
                            state_n_s = ST_PUNCH;
                            tick_n_s  = {TW{1'b0}};
                            idx_n_s   = 2'd0;
                            stun_n_s  = 2'd0;
                        end else if (rest_state_s != state_r) begin
                            state_n_s = rest_state_s;
                            tick_n_s  = {TW{1'b0}};
                            idx_n_s   = 2'd0;
                            stun_n_s  = 2'd0;
                        end else if (tick_wrap_s) begin
                            idx_n_s = (idx_r == IDLE_LAST) ? 2'd0 : (idx_r + 2'd1);
                        end else begin
                            idx_n_s = idx_r;
                        end
                    end
                    ST_PUNCH: begin
                        if (tick_wrap_s && (idx_r == PUNCH_LAST)) begin
                            state_n_s = rest_state_s;
                            tick_n_s  = {TW{1'b0}};
                            idx_n_s   = 2'd0;
                            stun_n_s  = 2'd0;
                        end else if (tick_wrap_s) begin
                            idx_n_s = idx_r + 2'd1;
                        end else begin
                            idx_n_s = idx_r;
                        end
                    end
                    ST_HIT: begin
                        // frame_idx is pinned at 0; the stun counter tracks animation-frame wraps instead
                        if (tick_wrap_s && (stun_r == HIT_LAST)) begin
                            state_n_s = rest_state_s;
                            tick_n_s  = {TW{1'b0}};
                            idx_n_s   = 2'd0;
                            stun_n_s  = 2'd0;
                        end else if (tick_wrap_s) begin
                            stun_n_s = stun_r + 2'd1;
                        end else begin
                            stun_n_s = stun_r;
                        end
                    end
                    default: begin
                        state_n_s = ST_IDLE;
                        tick_n_s  = {TW{1'b0}};
                        idx_n_s   = 2'd0;
                        stun_n_s  = 2'd0;
                    end
                endcase
            end
        end else begin
            state_n_s = state_r;
        end

        busy_n_s = (state_n_s == ST_PUNCH) || (state_n_s == ST_HIT);
    end

    // Shadow copies of position and facing so a mid-frame update cannot tear the sprite.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            pos_x_r <= 10'd0;
            pos_y_r <= 10'd0;
            flip_r  <= 1'b0;
        end else if (bus.frame_start) begin
            pos_x_r <= bus.PosX;
            pos_y_r <= bus.PosY;
            flip_r  <= bus.facing_left;
        end else begin
            pos_x_r <= pos_x_r;
            pos_y_r <= pos_y_r;
            flip_r  <= flip_r;
        end
    end

    // Hitbox test and box-to-sprite scaling with optional horizontal mirror.
    always_comb begin
        rel_x_s  = bus.DrawX - pos_x_r;
        rel_y_s  = bus.DrawY - pos_y_r;
        inside_s = (bus.DrawX >= pos_x_r) && (rel_x_s < BOX_W10) &&
                   (bus.DrawY >= pos_y_r) && (rel_y_s < BOX_H10);
        col_s    = ({7'd0, rel_x_s} * SPR_W17) / BOX_W17;
        row_s    = ({7'd0, rel_y_s} * SPR_H17) / BOX_H17;
        if (flip_r) begin
            col_m_s = SPR_W17 - 17'd1 - col_s;
        end else begin
            col_m_s = col_s;
        end
        if (inside_s) begin
            addr_s = 13'(row_s * SPR_W17 + col_m_s);
        end else begin
            addr_s = 13'd0;
        end
    end

    // Pixel outputs are one cycle behind DrawX/DrawY; the ROM samples them on the falling edge.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rom_address_r <= 13'd0;
            sprite_on_r   <= 1'b0;
        end else begin
            rom_address_r <= addr_s;
            sprite_on_r   <= inside_s;
        end
    end

    assign bus.anim_state  = state_r;
    assign bus.frame_idx   = idx_r;
    assign bus.busy        = busy_r;
    assign bus.flip        = flip_r;
    assign bus.rom_address = rom_address_r;
    assign bus.sprite_on   = sprite_on_r;

endmodule

// File: tb/tb_fighter_anim_controller.sv
// Directed bench for fighter_anim_controller: animation cycles, priority/restart,
// sprite addressing with mirroring, tear-free latching and mid-sequence reset.
module tb_fighter_anim_controller;

    logic vga_clk;
    logic Reset;
    int   n_pass;
    int   n_total;

    fighter_anim_if bus ();

    fighter_anim_controller dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus.slave)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        @(negedge vga_clk);
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input int exp_addr, input int exp_on);
        @(negedge vga_clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        @(negedge vga_clk);
        chk({tag, "_addr"}, int'(bus.rom_address), exp_addr);
        chk({tag, "_on"}, int'(bus.sprite_on), exp_on);
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        Reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.DrawX       = 10'd0;
        bus.DrawY       = 10'd0;
        bus.PosX        = 10'd0;
        bus.PosY        = 10'd0;
        bus.facing_left = 1'b0;
        bus.move_req    = 1'b0;
        bus.punch_req   = 1'b0;
        bus.hit_req     = 1'b0;

        // Reset values
        repeat (3) @(negedge vga_clk);
        chk("rst_state", int'(bus.anim_state), 0);
        chk("rst_idx", int'(bus.frame_idx), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_flip", int'(bus.flip), 0);
        chk("rst_addr", int'(bus.rom_address), 0);
        chk("rst_on", int'(bus.sprite_on), 0);
        Reset = 1'b0;

        // Idle cycle: frame_idx steps every 8 pulses and wraps after 32
        for (int k = 1; k <= 32; k++) begin
            frame_pulse();
            chk("idle_idx", int'(bus.frame_idx), (k / 8) % 4);
            chk("idle_state", int'(bus.anim_state), 0);
            chk("idle_busy", int'(bus.busy), 0);
        end

        // Punch with move held: 3 frames of 8 pulses, then WALK
        bus.move_req  = 1'b1;
        bus.punch_req = 1'b1;
        frame_pulse();
        bus.punch_req = 1'b0;
        chk("punch_entry_state", int'(bus.anim_state), 2);
        chk("punch_entry_busy", int'(bus.busy), 1);
        chk("punch_entry_idx", int'(bus.frame_idx), 0);
        for (int k = 1; k <= 24; k++) begin
            frame_pulse();
            if (k < 24) begin
                chk("punch_state", int'(bus.anim_state), 2);
                chk("punch_idx", int'(bus.frame_idx), k / 8);
            end else begin
                chk("punch_exit_state", int'(bus.anim_state), 1);
                chk("punch_exit_idx", int'(bus.frame_idx), 0);
                chk("punch_exit_busy", int'(bus.busy), 0);
            end
        end

        // Hit beats punch; second hit 8 pulses later restarts stun
        bus.move_req  = 1'b0;
        bus.punch_req = 1'b1;
        bus.hit_req   = 1'b1;
        frame_pulse();
        bus.punch_req = 1'b0;
        bus.hit_req   = 1'b0;
        chk("hit_entry_state", int'(bus.anim_state), 3);
        chk("hit_entry_busy", int'(bus.busy), 1);
        chk("hit_entry_idx", int'(bus.frame_idx), 0);
        repeat (7) frame_pulse();
        chk("hit_mid_state", int'(bus.anim_state), 3);
        bus.hit_req = 1'b1;
        frame_pulse();
        bus.hit_req = 1'b0;
        chk("hit_restart_state", int'(bus.anim_state), 3);
        repeat (15) frame_pulse();
        chk("hit_hold_state", int'(bus.anim_state), 3);
        chk("hit_hold_idx", int'(bus.frame_idx), 0);
        frame_pulse();
        chk("hit_exit_state", int'(bus.anim_state), 0);
        chk("hit_exit_busy", int'(bus.busy), 0);

        // Sprite addressing, not mirrored
        bus.PosX = 10'd100;
        bus.PosY = 10'd200;
        frame_pulse();
        chk("flip_off", int'(bus.flip), 0);
        pix("a_tl", 100, 200, 0, 1);
        pix("a_br", 179, 359, 5399, 1);
        pix("a_mid", 140, 280, 2730, 1);
        pix("a_right_out", 180, 359, 0, 0);
        pix("a_left_out", 99, 200, 0, 0);
        pix("a_bottom_out", 150, 360, 0, 0);

        // Mirrored
        bus.facing_left = 1'b1;
        frame_pulse();
        chk("flip_on", int'(bus.flip), 1);
        pix("m_tl", 100, 200, 59, 1);
        pix("m_br", 179, 359, 5340, 1);
        pix("m_mid", 140, 280, 2729, 1);

        // Tearing: new PosX ignored until next frame_start
        bus.PosX = 10'd300;
        pix("t_old", 100, 200, 59, 1);
        frame_pulse();
        pix("t_old_gone", 100, 200, 0, 0);
        pix("t_new", 300, 200, 59, 1);

        // Reset mid-punch at frame_idx=1
        bus.punch_req = 1'b1;
        frame_pulse();
        bus.punch_req = 1'b0;
        repeat (8) frame_pulse();
        chk("rp_state", int'(bus.anim_state), 2);
        chk("rp_idx", int'(bus.frame_idx), 1);
        @(negedge vga_clk);
        Reset = 1'b1;
        #1;
        chk("rp_rst_state", int'(bus.anim_state), 0);
        chk("rp_rst_idx", int'(bus.frame_idx), 0);
        chk("rp_rst_busy", int'(bus.busy), 0);
        chk("rp_rst_flip", int'(bus.flip), 0);
        chk("rp_rst_addr", int'(bus.rom_address), 0);
        chk("rp_rst_on", int'(bus.sprite_on), 0);
        @(negedge vga_clk);
        Reset = 1'b0;
        frame_pulse();
        chk("rp_after_state", int'(bus.anim_state), 0);
        chk("rp_after_idx", int'(bus.frame_idx), 0);
        chk("rp_after_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
